uart_rx_param: RTL and testbench



---
 rtl/uart_rx_param.sv | 130 +++++++++++++
 tb/tb_uart_rx_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (5..9 data bits, none/odd/even parity, 1 or 2 stop bits)
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 majority vote around the bit centre).
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx_uart    in   serial line, idle high, asynchronous to clk
//   rx_data    out  last received word, LSB = first data bit, held until next frame
//   rx_valid   out  one-cycle strobe when a frame completes (with or without error)
//   frame_err  out  a stop bit was sampled low; meaningful while rx_valid=1
//   parity_err out  parity mismatch; meaningful while rx_valid=1; 0 when PARITY=0
//   busy       out  high from start-edge detection until the FSM returns to IDLE
module uart_rx_param #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_uart,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);
  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT);
  localparam int IW      = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
  localparam int SMP = HALF + 1;
`else
  localparam int SMP = HALF;
`endif
  localparam logic [CW-1:0] C_SMP  = CW'(SMP);
  localparam logic [CW-1:0] C_LAST = CW'(BIT_CNT - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] S_LAST = IW'(STOP_BITS - 1);
  if (BIT_CNT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
    $error("uart_rx_param: illegal configuration (BIT_CNT<4 or parameter out of range)");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t               r_state;
  logic                 r_s1, r_s2, r_prev;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr, r_perr;
  logic                 w_bit, w_fall, w_smp, w_last;
`ifdef UART_RX_MAJORITY_EN
  // r_hist holds the synchronised line at cnt = HALF-1 and HALF when cnt reaches HALF+1
  logic [1:0] r_hist;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_hist <= 2'b11;
    else r_hist <= {r_hist[0], r_s2};
  assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_s2) | (r_hist[0] & r_s2);
`else
  assign w_bit = r_s2;
`endif
  // only a real 1->0 transition starts a frame; a line stuck low does not
  assign w_fall = r_prev & ~r_s2;
  assign w_smp  = r_cnt == C_SMP;
  assign w_last = r_cnt == C_LAST;
  assign busy   = r_state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1       <= 1'b1;
      r_s2       <= 1'b1;
      r_prev     <= 1'b1;
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      r_s1     <= rx_uart;
      r_s2     <= r_s1;
      r_prev   <= r_s2;
      rx_valid <= 1'b0;
      r_cnt    <= (r_state == IDLE || w_last) ? '0 : r_cnt + 1'b1;
      case (r_state)
        IDLE: if (w_fall) begin
          r_state <= START;
          r_ferr  <= 1'b0;
          r_perr  <= 1'b0;
        end
        START: if (w_smp && w_bit) r_state <= IDLE;
        else if (w_last) begin
          r_state <= DATA;
          r_idx   <= '0;
        end
        DATA: begin
          if (w_smp) r_shift[r_idx] <= w_bit;
          if (w_last) begin
            r_idx <= (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
            if (r_idx == I_LAST) r_state <= (PARITY != 0) ? PAR : STOP;
          end
        end
        // error when the XOR of data and parity bit differs from the wanted polarity
        PAR: begin
          if (w_smp) r_perr <= ^r_shift ^ w_bit ^ (PARITY == 1);
          if (w_last) r_state <= STOP;
        end
        // commit at the centre of the last stop bit so a back-to-back start edge is not missed
        STOP: begin
          if (w_smp) begin
            r_ferr <= r_ferr | ~w_bit;
            if (r_idx == S_LAST) begin
              rx_data    <= r_shift;
              frame_err  <= r_ferr | ~w_bit;
              parity_err <= r_perr;
              rx_valid   <= 1'b1;
              r_state    <= IDLE;
            end
          end
          if (w_last) r_idx <= r_idx + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and random frames on an 8N1 and an 8E2 receiver against a frame-level model
module tb_uart_rx_param;
  localparam int BC_A = 16, HA = BC_A / 2;
  localparam int BC_B = 13, HB = BC_B / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif
  typedef struct {
    logic [7:0] d;
    logic       f, p, b, pb;
    int         c;
  } ev_t;
  logic       clk = 1'b0, rst_n = 1'b0, rx_a = 1'b1, rx_b = 1'b1;
  logic [7:0] a_data, b_data;
  logic       a_valid, a_ferr, a_perr, a_busy;
  logic       b_valid, b_ferr, b_perr, b_busy;
  logic       pba = 1'b0, pbb = 1'b0;
  int         cyc = 0, n_assert = 0, n_fail = 0;
  ev_t        qa[$], qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rx_uart(rx_a), .rx_data(a_data), .rx_valid(a_valid),
    .frame_err(a_ferr), .parity_err(a_perr), .busy(a_busy));
  uart_rx_param #(.CLK_FREQ(1300), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .rx_uart(rx_b), .rx_data(b_data), .rx_valid(b_valid),
    .frame_err(b_ferr), .parity_err(b_perr), .busy(b_busy));

  always @(negedge clk) begin
    if (a_valid) qa.push_back(ev_t'{a_data, a_ferr, a_perr, a_busy, pba, cyc});
    if (b_valid) qb.push_back(ev_t'{b_data, b_ferr, b_perr, b_busy, pbb, cyc});
    pba <= a_busy;
    pbb <= b_busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int u, input logic v);
    if (u == 0) rx_a = v;
    else rx_b = v;
  endtask

  // one frame on line u; optional 1-cycle inversion at (gbit, goff); abort mid-bit abort_bit
  task automatic send(input int u, input logic [7:0] d, input logic pbit, input logic [1:0] sb,
                      input int gbit, input int goff, input int abort_bit, input int gap,
                      output int t0);
    int   bc;
    logic bits[$];
    bc = (u == 0) ? BC_A : BC_B;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (u == 1) bits.push_back(pbit);
    bits.push_back(sb[0]);
    if (u == 1) bits.push_back(sb[1]);
    t0 = cyc;
    for (int i = 0; i < bits.size(); i++)
      for (int c = 0; c < bc; c++) begin
        if (i == abort_bit && c == bc / 2) return;
        drive(u, (i == gbit && c == goff) ? ~bits[i] : bits[i]);
        tick(1);
      end
    for (int c = 0; c < gap; c++) begin
      drive(u, 1'b1);
      tick(1);
    end
  endtask

  // model: strobe = pin fall + 3 (detect) + HALF + (frame bits - 1) * BIT_CNT + 1
  task automatic expect_frame(input string tag, input int u, input logic [7:0] d, input logic pbit,
                              input logic [1:0] sb, input int t0);
    ev_t  e;
    int   nom, n;
    logic ef, ep;
    ef  = (u == 0) ? ~sb[0] : ~(sb[0] & sb[1]);
    ep  = (u == 0) ? 1'b0 : (^d ^ pbit);
    nom = t0 + 4 + ((u == 0) ? HA + 9 * BC_A : HB + 11 * BC_B) + D;
    n   = (u == 0) ? qa.size() : qb.size();
    chk({tag, ".count"}, n, 1);
    if (n > 0) begin
      if (u == 0) e = qa.pop_front();
      else e = qb.pop_front();
      chk({tag, ".data"}, e.d, d);
      chk({tag, ".frame_err"}, e.f, ef);
      chk({tag, ".parity_err"}, e.p, ep);
      chk({tag, ".busy_fall"}, {e.pb, e.b}, 2'b10);
      chk({tag, ".strobe_time_ok"}, (e.c >= nom - 1 && e.c <= nom + 1), 1);
    end
    if (u == 0) qa.delete();
    else qb.delete();
  endtask

  initial begin
    int         t;
    logic [7:0] d;
    logic       p, fe;
    logic [1:0] sb;
    tick(3);
    chk("reset.a", {a_data, a_valid, a_ferr, a_perr, a_busy}, 0);
    chk("reset.b", {b_data, b_valid, b_ferr, b_perr, b_busy}, 0);
    rst_n = 1'b1;
    tick(100);
    send(0, 8'h31, 1'b0, 2'b11, -1, 0, -1, 0, t);
    expect_frame("8n1_31", 0, 8'h31, 1'b0, 2'b11, t);
    send(0, 8'hA5, 1'b0, 2'b11, -1, 0, -1, 0, t);
    expect_frame("b2b_A5", 0, 8'hA5, 1'b0, 2'b11, t);
    send(0, 8'h5A, 1'b0, 2'b11, -1, 0, -1, 0, t);
    expect_frame("b2b_5A", 0, 8'h5A, 1'b0, 2'b11, t);
    tick(BC_A);
    send(1, 8'h07, 1'b1, 2'b11, -1, 0, -1, 0, t);
    expect_frame("even_07_p1", 1, 8'h07, 1'b1, 2'b11, t);
    send(1, 8'h07, 1'b0, 2'b11, -1, 0, -1, 0, t);
    expect_frame("even_07_p0", 1, 8'h07, 1'b0, 2'b11, t);
    send(0, 8'h55, 1'b0, 2'b00, -1, 0, -1, 0, t);
    expect_frame("ferr_55", 0, 8'h55, 1'b0, 2'b00, t);
    tick(3 * BC_A);
    chk("stuck_low.no_strobe", qa.size(), 0);
    chk("stuck_low.busy", a_busy, 0);
    drive(0, 1'b1);
    tick(BC_A);
    send(0, 8'h55, 1'b0, 2'b11, -1, 0, -1, 0, t);
    expect_frame("after_ferr_55", 0, 8'h55, 1'b0, 2'b11, t);
    drive(0, 1'b0);
    tick(4);
    chk("false_start.busy_high", a_busy, 1);
    drive(0, 1'b1);
    tick(2 * BC_A);
    chk("false_start.no_strobe", qa.size(), 0);
    chk("false_start.busy_low", a_busy, 0);
    drive(0, 1'b0);
    tick(1);
    drive(0, 1'b1);
    tick(2 * BC_A);
    chk("glitch_start.no_strobe", qa.size(), 0);
    chk("glitch_start.busy_low", a_busy, 0);
    send(0, 8'hC3, 1'b0, 2'b11, -1, 0, -1, 0, t);
    expect_frame("after_false_C3", 0, 8'hC3, 1'b0, 2'b11, t);
`ifdef UART_RX_MAJORITY_EN
    for (int o = HA - 1; o <= HA + 4; o++) begin
      send(0, 8'h00, 1'b0, 2'b11, 3, o, -1, 2, t);
      expect_frame("maj_glitch_00", 0, 8'h00, 1'b0, 2'b11, t);
    end
`endif
    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom);
      fe = ($urandom_range(0, 3) == 0);
      sb = fe ? 2'b00 : 2'b11;
      send(0, d, 1'b0, sb, -1, 0, -1, fe ? $urandom_range(2, 5) : $urandom_range(0, 3), t);
      expect_frame("rand_a", 0, d, 1'b0, sb, t);
    end
    for (int i = 0; i < 24; i++) begin
      d  = 8'($urandom);
      p  = 1'($urandom);
      sb = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      send(1, d, p, sb, -1, 0, -1, sb[1] ? $urandom_range(0, 3) : $urandom_range(2, 5), t);
      expect_frame("rand_b", 1, d, p, sb, t);
    end
    send(0, 8'hE7, 1'b0, 2'b11, -1, 0, -1, 0, t);
    expect_frame("pre_rst_E7", 0, 8'hE7, 1'b0, 2'b11, t);
    send(0, 8'hE7, 1'b0, 2'b11, -1, 0, 5, 0, t);
    chk("mid_rst.busy_before", a_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst.a_outputs", {a_data, a_valid, a_ferr, a_perr, a_busy}, 0);
    tick(3);
    drive(0, 1'b1);
    rst_n = 1'b1;
    tick(20);
    chk("mid_rst.no_strobe", qa.size(), 0);
    send(0, 8'h81, 1'b0, 2'b11, -1, 0, -1, 0, t);
    expect_frame("after_rst_81", 0, 8'h81, 1'b0, 2'b11, t);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
